// File: rtl/rob_completion_buffer_pkg.sv
// Shared sizing for the reorder-buffer completion slice.
// Tag width sets the depth; data and register widths match the datapath.
package rob_completion_buffer_pkg;

    localparam int unsigned DataSize = 32;
    localparam int unsigned RobWidth = 3;
    localparam int unsigned RegWidth = 5;
    localparam int unsigned RobDepth = 1 << RobWidth;

endpackage

// File: rtl/rob_completion_buffer_rob_entry.sv
// One reorder-buffer slot: valid/done flags, destination, write flag and result data.
// Strobes arrive pre-decoded from the top; writebacks are already gated by the pre-edge valid.
module rob_completion_buffer_rob_entry #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 alloc_i,
    input  logic [REG_WIDTH-1:0] alloc_dest_i,
    input  logic                 alloc_wr_i,
    input  logic                 wb0_i,
    input  logic [DATA_SIZE-1:0] wb0_data_i,
    input  logic                 wb1_i,
    input  logic [DATA_SIZE-1:0] wb1_data_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output logic                 done_o,
    output logic [REG_WIDTH-1:0] dest_o,
    output logic                 wr_o,
    output logic [DATA_SIZE-1:0] data_o
);

    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [REG_WIDTH-1:0] dest_q, dest_d;
    logic                 wr_q, wr_d;
    logic [DATA_SIZE-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            dest_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            dest_q  <= dest_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    // Flush drops the flags only; stale data stays in place.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dest_d  = dest_q;
        wr_d    = wr_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            if (alloc_i) begin
                valid_d = 1'b1;
                done_d  = 1'b0;
                dest_d  = alloc_dest_i;
                wr_d    = alloc_wr_i;
            end
            if (wb0_i) begin
                done_d = 1'b1;
                data_d = wb0_data_i;
            end
            // MUL path is applied last so it wins a same-tag collision.
            if (wb1_i) begin
                done_d = 1'b1;
                data_d = wb1_data_i;
            end
            if (clear_i) begin
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign dest_o  = dest_q;
    assign wr_o    = wr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rob_completion_buffer.sv
// Reorder-buffer completion and in-order commit: tag issue at dispatch, writeback marking,
// program-order retirement and a tag-indexed operand lookup.
module rob_completion_buffer
    import rob_completion_buffer_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DataSize,
    parameter int unsigned ROB_WIDTH = RobWidth,
    parameter int unsigned REG_WIDTH = RegWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 alloc_valid_i,
    input  logic [REG_WIDTH-1:0] alloc_dest_i,
    input  logic                 alloc_wr_i,
    output logic                 alloc_ready_o,
    output logic [ROB_WIDTH-1:0] alloc_tag_o,
    input  logic                 wb0_valid_i,
    input  logic [ROB_WIDTH-1:0] wb0_tag_i,
    input  logic [DATA_SIZE-1:0] wb0_data_i,
    input  logic                 wb1_valid_i,
    input  logic [ROB_WIDTH-1:0] wb1_tag_i,
    input  logic [DATA_SIZE-1:0] wb1_data_i,
    output logic                 commit_valid_o,
    input  logic                 commit_ready_i,
    output logic [ROB_WIDTH-1:0] commit_tag_o,
    output logic [REG_WIDTH-1:0] commit_dest_o,
    output logic                 commit_wr_o,
    output logic [DATA_SIZE-1:0] commit_data_o,
    input  logic [ROB_WIDTH-1:0] src_tag_i,
    output logic                 src_ready_o,
    output logic [DATA_SIZE-1:0] src_data_o,
    output logic [ROB_WIDTH:0]   count_o
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FullCount = (ROB_WIDTH + 1)'(DEPTH);

    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic [DEPTH-1:0]     ent_valid, ent_done, ent_wr;
    logic [REG_WIDTH-1:0] ent_dest [DEPTH];
    logic [DATA_SIZE-1:0] ent_data [DEPTH];

    logic [DEPTH-1:0] alloc_sel, wb0_sel, wb1_sel, clear_sel;
    logic             alloc_fire, commit_fire;

    assign alloc_ready_o  = (count_q < FullCount);
    assign alloc_tag_o    = tail_q;
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;
    assign commit_valid_o = ent_valid[head_q] && ent_done[head_q];
    assign commit_fire    = commit_valid_o && commit_ready_i;

    // Writebacks only land on entries that were live before this edge.
    always_comb begin
        alloc_sel = '0;
        wb0_sel   = '0;
        wb1_sel   = '0;
        clear_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_sel[i] = alloc_fire && (tail_q == ROB_WIDTH'(i));
            wb0_sel[i]   = wb0_valid_i && (wb0_tag_i == ROB_WIDTH'(i)) && ent_valid[i];
            wb1_sel[i]   = wb1_valid_i && (wb1_tag_i == ROB_WIDTH'(i)) && ent_valid[i];
            clear_sel[i] = commit_fire && (head_q == ROB_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rob_completion_buffer_rob_entry #(
            .DATA_SIZE (DATA_SIZE),
            .REG_WIDTH (REG_WIDTH)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (flush_i),
            .alloc_i      (alloc_sel[g]),
            .alloc_dest_i (alloc_dest_i),
            .alloc_wr_i   (alloc_wr_i),
            .wb0_i        (wb0_sel[g]),
            .wb0_data_i   (wb0_data_i),
            .wb1_i        (wb1_sel[g]),
            .wb1_data_i   (wb1_data_i),
            .clear_i      (clear_sel[g]),
            .valid_o      (ent_valid[g]),
            .done_o       (ent_done[g]),
            .dest_o       (ent_dest[g]),
            .wr_o         (ent_wr[g]),
            .data_o       (ent_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + 1'b1;
            end
            if (commit_fire) begin
                head_d = head_q + 1'b1;
            end
            unique case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    assign commit_tag_o  = head_q;
    assign commit_dest_o = ent_dest[head_q];
    assign commit_wr_o   = ent_wr[head_q];
    assign commit_data_o = ent_data[head_q];

    assign src_ready_o = ent_valid[src_tag_i] && ent_done[src_tag_i];
    assign src_data_o  = ent_data[src_tag_i];
    assign count_o     = count_q;

endmodule
